// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage.
//   IN_W / OUT_W    : widths of the EX->MEM and MEM->WB buses
//   IN_*            : bit positions of the EX->MEM bus fields
//   mem_state_e     : data-SRAM handshake FSM encoding
//   SIZE_WORD       : data_sram_size code for a 32-bit access
package mem_stage_pkg;

  localparam int unsigned IN_W  = 138;
  localparam int unsigned OUT_W = 103;

  // EX->MEM: {valid,pc[32],IR[32],ld_w,mem_we,res_from_mem,gr_we,rkd[32],waddr[5],result[32]}
  localparam int unsigned IN_RESULT_LSB   = 0;
  localparam int unsigned IN_WADDR_LSB    = 32;
  localparam int unsigned IN_RKD_LSB      = 37;
  localparam int unsigned IN_GR_WE        = 69;
  localparam int unsigned IN_RES_FROM_MEM = 70;
  localparam int unsigned IN_MEM_WE       = 71;
  localparam int unsigned IN_LD_W         = 72;
  localparam int unsigned IN_IR_LSB       = 73;
  localparam int unsigned IN_PC_LSB       = 105;
  localparam int unsigned IN_VALID        = 137;

  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StDone = 2'd3
  } mem_state_e;

endpackage

// File: rtl/mem_sram_fsm.sv
// Data-SRAM handshake controller for the MEM stage. Tracks the single
// outstanding request and buffers the response until WB can take it.
//   in_valid/is_mem : current MEM instruction is valid / is a load or store
//   WB_allowin      : WB accepts on this edge
//   addr_ok/data_ok : SRAM request accepted / response present
//   rdata           : SRAM load data (valid with data_ok)
//   req             : SRAM request valid
//   readygo         : instruction may leave MEM this cycle
//   load_ready      : load data available this cycle
//   load_data       : live SRAM data on the response cycle, else buffered copy
module mem_sram_fsm
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic        is_mem,
  input  logic        WB_allowin,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic [31:0] rdata,
  output logic        req,
  output logic        readygo,
  output logic        load_ready,
  output logic [31:0] load_data
);

  mem_state_e  state_q, state_d;
  logic [31:0] rdata_buf_q;
  logic        resp_now;

  // data_ok only counts while a request is outstanding
  assign resp_now = (state_q == StWait) & data_ok;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      rdata_buf_q <= '0;
    end else begin
      state_q <= state_d;
      if (resp_now) begin
        rdata_buf_q <= rdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    unique case (state_q)
      StIdle: begin
        req = in_valid & is_mem;
        if (req && addr_ok) begin
          state_d = StWait;
        end else if (req) begin
          state_d = StReq;
        end
      end
      StReq: begin
        req = 1'b1;
        if (addr_ok) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (data_ok) begin
          state_d = WB_allowin ? StIdle : StDone;
        end
      end
      StDone: begin
        if (WB_allowin) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign load_ready = resp_now | (state_q == StDone);
  assign readygo    = ~is_mem | load_ready;
  assign load_data  = resp_now ? rdata : rdata_buf_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: unpacks the EX->MEM register, issues word load/store on
// the data-SRAM req/addr_ok/data_ok interface, merges load data with the ALU
// result into the MEM->WB register and provides a forwarding/stall tap to ID.
//   clk, resetn        : clock, async active-low reset
//   EX_to_MEM_reg      : stage input register (written by EX when MEM_allowin)
//   WB_allowin         : WB accepts on this edge
//   MEM_allowin        : MEM can accept a new instruction
//   data_sram_*        : SRAM request/response channel
//   front_*            : forwarding value and load-use stall to ID
//   MEM_to_WB_reg      : registered output bus
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic [IN_W-1:0]  EX_to_MEM_reg,
  input  logic             WB_allowin,
  output logic             MEM_allowin,
  output logic             data_sram_req,
  output logic             data_sram_wr,
  output logic [1:0]       data_sram_size,
  output logic [3:0]       data_sram_wstrb,
  output logic [31:0]      data_sram_addr,
  output logic [31:0]      data_sram_wdata,
  input  logic             data_sram_addr_ok,
  input  logic             data_sram_data_ok,
  input  logic [31:0]      data_sram_rdata,
  output logic             front_valid,
  output logic [4:0]       front_addr,
  output logic [31:0]      front_data,
  output logic             front_stall,
  output logic [OUT_W-1:0] MEM_to_WB_reg
);

  logic        in_valid, mem_we, res_from_mem, gr_we, is_mem;
  logic [31:0] pc, ir, rkd, result;
  logic [4:0]  waddr;
  logic        readygo, load_ready;
  logic [31:0] load_data, final_result;
  logic        unused_ld_w;

  assign in_valid     = EX_to_MEM_reg[IN_VALID];
  assign pc           = EX_to_MEM_reg[IN_PC_LSB +: 32];
  assign ir           = EX_to_MEM_reg[IN_IR_LSB +: 32];
  assign mem_we       = EX_to_MEM_reg[IN_MEM_WE];
  assign res_from_mem = EX_to_MEM_reg[IN_RES_FROM_MEM];
  assign gr_we        = EX_to_MEM_reg[IN_GR_WE];
  assign rkd          = EX_to_MEM_reg[IN_RKD_LSB +: 32];
  assign waddr        = EX_to_MEM_reg[IN_WADDR_LSB +: 5];
  assign result       = EX_to_MEM_reg[IN_RESULT_LSB +: 32];
  // Only word accesses exist, so the load-width flag carries no information here
  assign unused_ld_w  = EX_to_MEM_reg[IN_LD_W];

  assign is_mem = mem_we | res_from_mem;

  mem_sram_fsm u_fsm (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .is_mem     (is_mem),
    .WB_allowin (WB_allowin),
    .addr_ok    (data_sram_addr_ok),
    .data_ok    (data_sram_data_ok),
    .rdata      (data_sram_rdata),
    .req        (data_sram_req),
    .readygo    (readygo),
    .load_ready (load_ready),
    .load_data  (load_data)
  );

  assign MEM_allowin     = ~in_valid | (readygo & WB_allowin);
  // addr/wdata/wr stay stable while waiting because MEM_allowin holds EX off
  assign data_sram_wr    = mem_we;
  assign data_sram_size  = SIZE_WORD;
  assign data_sram_wstrb = mem_we ? 4'hf : 4'h0;
  assign data_sram_addr  = result;
  assign data_sram_wdata = rkd;

  assign final_result = res_from_mem ? load_data : result;

  assign front_stall = in_valid & res_from_mem & ~load_ready;
  assign front_valid = in_valid & gr_we & ~front_stall;
  assign front_addr  = waddr;
  assign front_data  = final_result;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      MEM_to_WB_reg <= '0;
    end else if (WB_allowin) begin
      MEM_to_WB_reg <= {in_valid & readygo, pc, ir, gr_we, waddr, final_result};
    end
  end

endmodule
